// File: rtl/palette_pkg.sv
// Shared types, constants and the channel-scaling helper for the palette block.
package palette_pkg;

  typedef logic [11:0] rgb12_t;
  typedef logic [4:0]  level_t;

  localparam level_t LEVEL_MAX = 5'd16;

  // Power-up grey ramp loaded into both banks on reset.
  localparam rgb12_t DEFAULT_PALETTE [16] = '{
    12'hFFF, 12'h222, 12'h999, 12'h555,
    12'hCCC, 12'h000, 12'h777, 12'hDDD,
    12'h111, 12'hCCC, 12'hAAA, 12'h444,
    12'hBBB, 12'h666, 12'h888, 12'h000
  };

  typedef enum logic {IDLE, FADING} fade_state_e;

  // (c * lvl) >> 4; lvl=16 returns c unchanged, lvl=0 returns 0.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input level_t lvl);
    logic [7:0] p;
    p = {4'b0, c} * {3'b0, lvl};
    return 4'(p >> 4);
  endfunction

endpackage

// File: rtl/palette_fade_seq.sv
// Frame-stepped brightness fade: FSM, frame counter and level register.
module palette_fade_seq
  import palette_pkg::*;
#(
  parameter int FADE_FRAMES = 4,
  parameter int FADE_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        fade_start,
  input  logic        fade_dir,
  output level_t      level,
  output logic        fade_busy,
  output logic        fade_done,
  output fade_state_e state
);

  localparam logic [7:0] LAST_FRAME = 8'(FADE_FRAMES - 1);
  localparam logic [5:0] STEP       = 6'(FADE_STEP);

  fade_state_e state_n;
  logic [7:0]  cnt, cnt_n;
  logic        dir, dir_n;
  logic        done_n;
  level_t      level_n, target, stepped;

  assign target    = dir ? LEVEL_MAX : 5'd0;
  assign fade_busy = (state == FADING);

  // One step toward the target, saturating at it.
  always_comb begin
    stepped = level;
    if (dir) begin
      if (({1'b0, level} + STEP) >= 6'(LEVEL_MAX)) stepped = LEVEL_MAX;
      else                                          stepped = 5'({1'b0, level} + STEP);
    end else begin
      if ({1'b0, level} <= STEP) stepped = 5'd0;
      else                       stepped = 5'({1'b0, level} - STEP);
    end
  end

  // Next-state logic; a fade already at its target finishes on the next frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir;
    level_n = level;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (fade_start) begin
          state_n = FADING;
          cnt_n   = 8'd0;
          dir_n   = fade_dir;
        end
      end
      FADING: begin
        if (frame_start) begin
          if (level == target) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (cnt == LAST_FRAME) begin
            cnt_n   = 8'd0;
            level_n = stepped;
            if (stepped == target) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; reset aborts any fade and restores full brightness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      dir       <= 1'b0;
      level     <= LEVEL_MAX;
      fade_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dir       <= dir_n;
      level     <= level_n;
      fade_done <= done_n;
    end
  end

endmodule

// File: rtl/palette_ctrl.sv
// Double-banked 16-entry palette with frame-synchronous commit, fade and a
// two-stage scaled lookup pipeline.
//
// Host write handshake: a write transfers on a rising clk edge where
// wr_valid && wr_ready; wr_ready depends only on commit_pending, never on
// wr_valid, and the host holds wr_index/wr_rgb stable while wr_valid is high.
module palette_ctrl
  import palette_pkg::*;
#(
  parameter int FADE_FRAMES = 4,
  parameter int FADE_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_index,
  input  logic [11:0] wr_rgb,
  input  logic        commit,
  output logic        commit_pending,
  input  logic        fade_start,
  input  logic        fade_dir,
  output logic        fade_busy,
  output logic        fade_done,
  output logic [4:0]  level,
  input  logic        pix_valid_in,
  input  logic [3:0]  pix_index,
  output logic        pix_valid_out,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output fade_state_e fade_state
);

  rgb12_t shadow [16];
  rgb12_t active [16];
  rgb12_t s1_rgb;
  logic   s1_valid;
  logic   wr_fire, apply;

  assign wr_ready = ~commit_pending;
  assign wr_fire  = wr_valid & wr_ready;
  assign apply    = commit_pending & frame_start;

  // Host-side shadow bank; frozen while a commit is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) shadow[i] <= DEFAULT_PALETTE[i];
    end else if (wr_fire) begin
      shadow[wr_index] <= wr_rgb;
    end
  end

  // Commit request; cleared by the frame_start that applies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         commit_pending <= 1'b0;
    else if (apply)  commit_pending <= 1'b0;
    else if (commit) commit_pending <= 1'b1;
  end

  // Active bank is copied from shadow in one cycle at vertical blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) active[i] <= DEFAULT_PALETTE[i];
    end else if (apply) begin
      for (int i = 0; i < 16; i++) active[i] <= shadow[i];
    end
  end

  palette_fade_seq #(
    .FADE_FRAMES (FADE_FRAMES),
    .FADE_STEP   (FADE_STEP)
  ) u_fade (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .fade_start  (fade_start),
    .fade_dir    (fade_dir),
    .level       (level),
    .fade_busy   (fade_busy),
    .fade_done   (fade_done),
    .state       (fade_state)
  );

  // Pixel stage 1: palette lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_rgb   <= 12'h000;
      s1_valid <= 1'b0;
    end else begin
      s1_rgb   <= active[pix_index];
      s1_valid <= pix_valid_in;
    end
  end

  // Pixel stage 2: brightness scaling with the level current in this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red           <= 4'h0;
      green         <= 4'h0;
      blue          <= 4'h0;
      pix_valid_out <= 1'b0;
    end else begin
      red           <= scale_chan(s1_rgb[11:8], level);
      green         <= scale_chan(s1_rgb[7:4],  level);
      blue          <= scale_chan(s1_rgb[3:0],  level);
      pix_valid_out <= s1_valid;
    end
  end

endmodule

// File: tb/tb_palette_ctrl.sv
// Bench for palette_ctrl: two instances (fast fade 1/8 and slow fade 4/1)
// share one stimulus stream and are checked against a behavioural model.
module tb_palette_ctrl;
  import palette_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        frame_start = 1'b0, wr_valid = 1'b0, commit = 1'b0;
  logic        fade_start = 1'b0, fade_dir = 1'b0, pix_valid_in = 1'b0;
  logic [3:0]  wr_index = 4'd0, pix_index = 4'd0;
  logic [11:0] wr_rgb = 12'h000;

  logic        a_wr_ready, a_pend, a_busy, a_done, a_pv;
  logic [4:0]  a_level;
  logic [3:0]  a_r, a_g, a_b;
  fade_state_e a_st;
  logic        b_wr_ready, b_pend, b_busy, b_done, b_pv;
  logic [4:0]  b_level;
  logic [3:0]  b_r, b_g, b_b;
  fade_state_e b_st;

  palette_ctrl #(.FADE_FRAMES(1), .FADE_STEP(8)) dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_ready(a_wr_ready), .wr_index(wr_index), .wr_rgb(wr_rgb), .commit(commit),
    .commit_pending(a_pend), .fade_start(fade_start), .fade_dir(fade_dir),
    .fade_busy(a_busy), .fade_done(a_done), .level(a_level),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index), .pix_valid_out(a_pv),
    .red(a_r), .green(a_g), .blue(a_b), .fade_state(a_st));

  palette_ctrl #(.FADE_FRAMES(4), .FADE_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_ready(b_wr_ready), .wr_index(wr_index), .wr_rgb(wr_rgb), .commit(commit),
    .commit_pending(b_pend), .fade_start(fade_start), .fade_dir(fade_dir),
    .fade_busy(b_busy), .fade_done(b_done), .level(b_level),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index), .pix_valid_out(b_pv),
    .red(b_r), .green(b_g), .blue(b_b), .fade_state(b_st));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int FF [2] = '{1, 4};
  localparam int FS [2] = '{8, 1};
  localparam int DEF [16] = '{'hFFF, 'h222, 'h999, 'h555, 'hCCC, 'h000, 'h777, 'hDDD,
                              'h111, 'hCCC, 'hAAA, 'h444, 'hBBB, 'h666, 'h888, 'h000};

  int m_shadow [16];
  int m_active [16];
  bit m_pend;
  int m_level [2];
  bit m_fading [2];
  int m_frames [2];
  bit m_dir [2];
  bit m_done [2];
  int m_s1c;
  bit m_s1v;
  int m_out [2];
  bit m_outv;

  function automatic int scale(int c, int lvl);
    int r, g, b;
    r = ((c / 256) % 16) * lvl / 16;
    g = ((c / 16) % 16) * lvl / 16;
    b = (c % 16) * lvl / 16;
    return r * 256 + g * 16 + b;
  endfunction

  // Level after one more frame of a fade: a step happens every ff-th frame.
  function automatic int after_frame(int lv, int frames_before, bit dir, int ff, int fs);
    int tgt;
    tgt = dir ? 16 : 0;
    if (lv == tgt) return lv;
    if ((frames_before + 1) % ff != 0) return lv;
    if (dir) return (lv + fs > 16) ? 16 : lv + fs;
    return (lv - fs < 0) ? 0 : lv - fs;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_shadow[i] <= DEF[i];
        m_active[i] <= DEF[i];
      end
      m_pend <= 1'b0;
      m_s1c  <= 0;
      m_s1v  <= 1'b0;
      m_outv <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_level[k]  <= 16;
        m_fading[k] <= 1'b0;
        m_frames[k] <= 0;
        m_dir[k]    <= 1'b0;
        m_done[k]   <= 1'b0;
        m_out[k]    <= 0;
      end
    end else begin
      if (wr_valid && !m_pend) m_shadow[wr_index] <= 32'(wr_rgb);
      if (commit && !m_pend) m_pend <= 1'b1;
      else if (m_pend && frame_start) begin
        m_pend   <= 1'b0;
        m_active <= m_shadow;
      end
      m_s1c  <= m_active[pix_index];
      m_s1v  <= pix_valid_in;
      m_outv <= m_s1v;
      for (int k = 0; k < 2; k++) begin
        m_out[k]  <= scale(m_s1c, m_level[k]);
        m_done[k] <= 1'b0;
        if (!m_fading[k]) begin
          if (fade_start) begin
            m_fading[k] <= 1'b1;
            m_frames[k] <= 0;
            m_dir[k]    <= fade_dir;
          end
        end else if (frame_start) begin
          m_frames[k] <= m_frames[k] + 1;
          m_level[k]  <= after_frame(m_level[k], m_frames[k], m_dir[k], FF[k], FS[k]);
          if (after_frame(m_level[k], m_frames[k], m_dir[k], FF[k], FS[k]) == (m_dir[k] ? 16 : 0)) begin
            m_fading[k] <= 1'b0;
            m_done[k]   <= 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cmp_wr_ready_a", 32'(a_wr_ready), 32'(!m_pend));
      check("cmp_wr_ready_b", 32'(b_wr_ready), 32'(!m_pend));
      check("cmp_pend_a", 32'(a_pend), 32'(m_pend));
      check("cmp_pend_b", 32'(b_pend), 32'(m_pend));
      check("cmp_level_a", 32'(a_level), 32'(m_level[0]));
      check("cmp_level_b", 32'(b_level), 32'(m_level[1]));
      check("cmp_busy_a", 32'(a_busy), 32'(m_fading[0]));
      check("cmp_busy_b", 32'(b_busy), 32'(m_fading[1]));
      check("cmp_done_a", 32'(a_done), 32'(m_done[0]));
      check("cmp_done_b", 32'(b_done), 32'(m_done[1]));
      check("cmp_pv_a", 32'(a_pv), 32'(m_outv));
      check("cmp_pv_b", 32'(b_pv), 32'(m_outv));
      if (m_outv) begin
        check("cmp_rgb_a", 32'({a_r, a_g, a_b}), 32'(m_out[0]));
        check("cmp_rgb_b", 32'({b_r, b_g, b_b}), 32'(m_out[1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic frame();
    tick(); frame_start = 1'b1;
    tick(); frame_start = 1'b0;
  endtask

  task automatic write(input logic [3:0] idx, input logic [11:0] rgb, input logic with_commit);
    tick(); wr_valid = 1'b1; wr_index = idx; wr_rgb = rgb; commit = with_commit;
    tick(); wr_valid = 1'b0; commit = 1'b0;
  endtask

  task automatic pulse_commit();
    tick(); commit = 1'b1;
    tick(); commit = 1'b0;
  endtask

  task automatic start_fade(input logic dir);
    tick(); fade_start = 1'b1; fade_dir = dir;
    tick(); fade_start = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [3:0] idx,
                        input logic [11:0] want_a, input logic [11:0] want_b);
    tick(); pix_valid_in = 1'b1; pix_index = idx;
    tick(); pix_valid_in = 1'b0;
    @(negedge clk);
    check({name, "_a"}, 32'({a_pv, a_r, a_g, a_b}), 32'({1'b1, want_a}));
    check({name, "_b"}, 32'({b_pv, b_r, b_g, b_b}), 32'({1'b1, want_b}));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level_a", 32'(a_level), 32'd16);
    check("rst_level_b", 32'(b_level), 32'd16);
    check("rst_wr_ready", 32'(a_wr_ready), 32'd1);
    check("rst_pend", 32'(a_pend), 32'd0);
    check("rst_busy_done", 32'({a_busy, a_done, b_busy, b_done}), 32'd0);
    check("rst_pix_a", 32'({a_pv, a_r, a_g, a_b}), 32'd0);
    check("rst_pix_b", 32'({b_pv, b_r, b_g, b_b}), 32'd0);
    #1 rst = 1'b0;

    // Reset defaults through the pipeline
    lookup("def_idx2", 4'd2, 12'h999, 12'h999);
    lookup("def_idx0", 4'd0, 12'hFFF, 12'hFFF);

    // Write then commit: old colour until frame_start
    write(4'd3, 12'hF00, 1'b0);
    pulse_commit();
    check("commit_wr_ready", 32'(a_wr_ready), 32'd0);
    check("commit_pending", 32'(a_pend), 32'd1);
    lookup("pre_commit_idx3", 4'd3, 12'h555, 12'h555);
    frame();
    check("applied_pending", 32'(a_pend), 32'd0);
    check("applied_wr_ready", 32'(b_wr_ready), 32'd1);
    lookup("post_commit_idx3", 4'd3, 12'hF00, 12'hF00);

    // Write in the commit cycle is included; write while pending is refused
    write(4'd5, 12'h0A0, 1'b1);
    write(4'd6, 12'h123, 1'b0);
    frame();
    lookup("same_cycle_idx5", 4'd5, 12'h0A0, 12'h0A0);
    lookup("refused_idx6", 4'd6, 12'h777, 12'h777);

    // Fade out: instance a steps 16 -> 8 -> 0 on consecutive frames
    start_fade(1'b0);
    frame();
    check("fade_out_level8_a", 32'(a_level), 32'd8);
    check("fade_out_hold_b", 32'(b_level), 32'd16);
    lookup("fade_level8_idx2", 4'd2, 12'h444, 12'h999);
    frame();
    check("fade_out_level0_a", 32'(a_level), 32'd0);
    check("fade_done_pulse_a", 32'(a_done), 32'd1);
    tick();
    check("fade_done_single_a", 32'(a_done), 32'd0);
    lookup("fade_black_idx0", 4'd0, 12'h000, 12'hFFF);
    n = 0;
    while (b_busy && n < 100) begin
      frame();
      n++;
    end
    check("fade_out_frames_b", 32'(n), 32'd62);
    check("fade_out_level0_b", 32'(b_level), 32'd0);

    // Fade in with a redundant start mid-fade on instance b
    start_fade(1'b1);
    for (int i = 1; i <= 64; i++) begin
      frame();
      if (i == 2) check("fade_in_level16_a", 32'(a_level), 32'd16);
      if (i == 10) start_fade(1'b0);
      if (i == 63) check("fade_in_f63_b", 32'({b_busy, b_level}), 32'({1'b1, 5'd15}));
      if (i == 64) check("fade_in_f64_b", 32'({b_done, b_level}), 32'({1'b1, 5'd16}));
    end

    // Async reset mid-fade with a commit pending
    start_fade(1'b0);
    frame();
    write(4'd1, 12'hABC, 1'b1);
    tick();
    rst = 1'b1;
    #2;
    check("async_level_a", 32'(a_level), 32'd16);
    check("async_level_b", 32'(b_level), 32'd16);
    check("async_busy_b", 32'(b_busy), 32'd0);
    check("async_pend", 32'({a_pend, b_pend}), 32'd0);
    check("async_pix", 32'({a_pv, b_pv}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    lookup("after_rst_idx1", 4'd1, 12'h222, 12'h222);
    lookup("after_rst_idx3", 4'd3, 12'h555, 12'h555);
    pulse_commit();
    frame();
    lookup("shadow_rst_idx1", 4'd1, 12'h222, 12'h222);
    lookup("shadow_rst_idx5", 4'd5, 12'h000, 12'h000);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
